// File: rtl/router_1xn.sv
// rtl/router_1xn.sv - parametrised 1xN packet router with per-channel FIFOs
module router_1xn #(
  parameter int NUM_PORTS  = 3,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int STORE_FWD  = 0,
  parameter int TIMEOUT    = 30
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        pkt_valid,
  input  logic [DATA_W-1:0]           data_in,
  input  logic [NUM_PORTS-1:0]        rd_en,
  output logic [NUM_PORTS-1:0]        valid_out,
  output logic [NUM_PORTS*DATA_W-1:0] data_out,
  output logic                        busy,
  output logic                        error,
  output logic                        drop
);
  localparam int ADDR_W = (NUM_PORTS > 2) ? $clog2(NUM_PORTS) : 1;
  localparam int LEN_W  = DATA_W - ADDR_W;
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int PTR_W  = AW + 1;
  localparam int CNT_W  = LEN_W + 1;
  localparam int TMR_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {S_IDLE, S_WAIT_SPACE, S_LOAD_DATA, S_CHECK, S_DROP} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] dest_q, dest_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [DATA_W-1:0] hdr_q, hdr_d;
  logic [DATA_W-1:0] par_q, par_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              error_q, error_d;
  logic              drop_q, drop_d;

  logic [PTR_W-1:0]  wr_q [NUM_PORTS];
  logic [PTR_W-1:0]  wr_d [NUM_PORTS];
  logic [PTR_W-1:0]  cm_q [NUM_PORTS];
  logic [PTR_W-1:0]  cm_d [NUM_PORTS];
  logic [PTR_W-1:0]  rd_q [NUM_PORTS];
  logic [PTR_W-1:0]  rd_d [NUM_PORTS];
  logic [TMR_W-1:0]  tmr_q [NUM_PORTS];
  logic [TMR_W-1:0]  tmr_d [NUM_PORTS];
  logic [DATA_W-1:0] dout_q [NUM_PORTS];
  logic [DATA_W-1:0] dout_d [NUM_PORTS];
  logic [DATA_W-1:0] mem [NUM_PORTS][FIFO_DEPTH];

  logic [PTR_W-1:0]     used_w [NUM_PORTS];
  int                   free_w [NUM_PORTS];
  logic [NUM_PORTS-1:0] full;
  logic [NUM_PORTS-1:0] active;
  logic [ADDR_W-1:0]    hdr_addr;
  logic [LEN_W-1:0]     hdr_len;
  logic [ADDR_W-1:0]    wr_sel;
  logic                 wr_en;
  logic [DATA_W-1:0]    wr_data;

  assign hdr_addr = data_in[ADDR_W-1:0];
  assign hdr_len  = data_in[DATA_W-1:ADDR_W];
  assign wr_sel   = (state_q == S_IDLE) ? hdr_addr : dest_q;
  assign error    = error_q;
  assign drop     = drop_q;

  // Per-channel occupancy, readability and the channel currently owned by the input FSM
  always_comb begin
    for (int k = 0; k < NUM_PORTS; k++) begin
      used_w[k]    = wr_q[k] - rd_q[k];
      full[k]      = (used_w[k] == PTR_W'(FIFO_DEPTH));
      free_w[k]    = FIFO_DEPTH - int'(used_w[k]);
      valid_out[k] = (cm_q[k] != rd_q[k]);
      active[k]    = (state_q inside {S_WAIT_SPACE, S_LOAD_DATA, S_CHECK}) && (dest_q == ADDR_W'(k));
      data_out[k*DATA_W +: DATA_W] = dout_q[k];
    end
  end

  // Source back-pressure: stalled while checking, waiting for room, or the target FIFO is full
  always_comb begin
    busy = (state_q == S_CHECK) || (state_q == S_WAIT_SPACE) ||
           ((state_q == S_LOAD_DATA) && full[dest_q]);
  end

  // Packet FSM next state: header decode, byte loading, parity/length check, drop
  always_comb begin
    state_d = state_q;
    dest_d  = dest_q;
    len_d   = len_q;
    hdr_d   = hdr_q;
    par_d   = par_q;
    cnt_d   = cnt_q;
    error_d = 1'b0;
    drop_d  = 1'b0;
    wr_en   = 1'b0;
    wr_data = data_in;
    case (state_q)
      S_IDLE: begin
        if (pkt_valid) begin
          dest_d = hdr_addr;
          len_d  = hdr_len;
          hdr_d  = data_in;
          if (int'(hdr_addr) >= NUM_PORTS) begin
            state_d = S_DROP;
          end else if ((STORE_FWD != 0) && (int'(hdr_len) + 2 > FIFO_DEPTH)) begin
            state_d = S_DROP;
          end else if ((STORE_FWD != 0) && (free_w[hdr_addr] < int'(hdr_len) + 2)) begin
            state_d = S_WAIT_SPACE;
          end else begin
            wr_en   = 1'b1;
            par_d   = data_in;
            cnt_d   = '0;
            state_d = S_LOAD_DATA;
          end
        end
      end
      S_WAIT_SPACE: begin
        if (free_w[dest_q] >= int'(len_q) + 2) begin
          wr_en   = 1'b1;
          wr_data = hdr_q;
          par_d   = hdr_q;
          cnt_d   = '0;
          state_d = S_LOAD_DATA;
        end
      end
      S_LOAD_DATA: begin
        if (!busy) begin
          wr_en = 1'b1;
          if (pkt_valid) begin
            par_d = par_q ^ data_in;
            if (!(&cnt_q)) cnt_d = cnt_q + 1'b1;
          end else begin
            error_d = (par_q != data_in) || (cnt_q != {1'b0, len_q});
            state_d = S_CHECK;
          end
        end
      end
      S_CHECK: state_d = S_IDLE;
      S_DROP: begin
        if (!pkt_valid) begin
          drop_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Pointer, commit/rollback, read data and timeout-flush next state per channel
  always_comb begin
    for (int k = 0; k < NUM_PORTS; k++) begin
      wr_d[k]   = wr_q[k];
      cm_d[k]   = cm_q[k];
      rd_d[k]   = rd_q[k];
      tmr_d[k]  = tmr_q[k];
      dout_d[k] = dout_q[k];
      if (wr_en && (wr_sel == ADDR_W'(k))) wr_d[k] = wr_q[k] + PTR_W'(1);
      if (rd_en[k] && valid_out[k]) begin
        rd_d[k]   = rd_q[k] + PTR_W'(1);
        dout_d[k] = mem[k][rd_q[k][AW-1:0]];
      end
      if (STORE_FWD == 0) begin
        cm_d[k] = wr_d[k];
      end else if ((state_q == S_CHECK) && (dest_q == ADDR_W'(k))) begin
        if (error_q) wr_d[k] = cm_q[k];
        else         cm_d[k] = wr_q[k];
      end
      if (!valid_out[k] || rd_en[k]) begin
        tmr_d[k] = '0;
      end else if (!active[k]) begin
        if (tmr_q[k] == TMR_W'(TIMEOUT - 1)) begin
          rd_d[k]  = cm_q[k];
          tmr_d[k] = '0;
        end else begin
          tmr_d[k] = tmr_q[k] + TMR_W'(1);
        end
      end
    end
  end

  // State and pointer registers, cleared asynchronously
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      dest_q  <= '0;
      len_q   <= '0;
      hdr_q   <= '0;
      par_q   <= '0;
      cnt_q   <= '0;
      error_q <= 1'b0;
      drop_q  <= 1'b0;
      for (int k = 0; k < NUM_PORTS; k++) begin
        wr_q[k]   <= '0;
        cm_q[k]   <= '0;
        rd_q[k]   <= '0;
        tmr_q[k]  <= '0;
        dout_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      dest_q  <= dest_d;
      len_q   <= len_d;
      hdr_q   <= hdr_d;
      par_q   <= par_d;
      cnt_q   <= cnt_d;
      error_q <= error_d;
      drop_q  <= drop_d;
      for (int k = 0; k < NUM_PORTS; k++) begin
        wr_q[k]   <= wr_d[k];
        cm_q[k]   <= cm_d[k];
        rd_q[k]   <= rd_d[k];
        tmr_q[k]  <= tmr_d[k];
        dout_q[k] <= dout_d[k];
      end
    end
  end

  // FIFO storage write; contents are don't-care until covered by the pointers
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_sel][wr_q[wr_sel][AW-1:0]] <= wr_data;
  end

endmodule

// File: tb/tb_router_1xn.sv
// tb/tb_router_1xn.sv - directed self-checking bench for router_1xn
module tb_router_1xn;
  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        pv = 1'b0;
  logic [7:0]  din = 8'h00;
  logic [2:0]  rd = 3'b000;
  logic [2:0]  rd_s = 3'b000;
  logic [2:0]  vo, vo_s;
  logic [23:0] dout, dout_s;
  logic        busy, error, drop;
  logic        busy_s, error_s, drop_s;

  router_1xn #(.NUM_PORTS(3), .DATA_W(8), .FIFO_DEPTH(16), .STORE_FWD(0), .TIMEOUT(30)) dut (
    .clk(clk), .rstn(rstn), .pkt_valid(pv), .data_in(din), .rd_en(rd),
    .valid_out(vo), .data_out(dout), .busy(busy), .error(error), .drop(drop));

  router_1xn #(.NUM_PORTS(3), .DATA_W(8), .FIFO_DEPTH(16), .STORE_FWD(1), .TIMEOUT(30)) dut_sf (
    .clk(clk), .rstn(rstn), .pkt_valid(pv), .data_in(din), .rd_en(rd_s),
    .valid_out(vo_s), .data_out(dout_s), .busy(busy_s), .error(error_s), .drop(drop_s));

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int err_cnt = 0, err_s_cnt = 0, drop_cnt = 0, busy_cnt = 0;
  logic [2:0] vo_seen = 3'b000;
  logic vo2_s_seen = 1'b0;
  int n_sent = 0;
  int first_busy_at = -1;
  int stall_tmo = 0;
  logic [7:0] pl [64];
  logic [7:0] exp_w [64];

  always @(negedge clk) begin
    if (error)   err_cnt++;
    if (error_s) err_s_cnt++;
    if (drop)    drop_cnt++;
    if (busy)    busy_cnt++;
    vo_seen = vo_seen | vo;
    if (vo_s[2]) vo2_s_seen = 1'b1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    err_cnt = 0; err_s_cnt = 0; drop_cnt = 0; busy_cnt = 0;
    vo_seen = 3'b000; vo2_s_seen = 1'b0;
  endtask

  task automatic send_byte(input logic v, input logic [7:0] b);
    int g;
    pv = v; din = b; g = 0;
    @(negedge clk);
    while (busy && g < 300) begin
      if (first_busy_at < 0) first_busy_at = n_sent;
      g++;
      @(negedge clk);
    end
    if (g >= 300) stall_tmo++;
    @(posedge clk); #1;
    n_sent++;
  endtask

  task automatic send_pkt(input logic [7:0] hdr, input int n, input logic [7:0] par);
    send_byte(1'b1, hdr);
    for (int i = 0; i < n; i++) send_byte(1'b1, pl[i]);
    send_byte(1'b0, par);
    pv = 1'b0; din = 8'h00;
  endtask

  task automatic read_chk(input int p, input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      rd[p] = 1'b1;
      @(posedge clk); #1;
      check($sformatf("%s[%0d]", tag, i), dout[p*8 +: 8], exp_w[i]);
    end
    rd[p] = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    #1 rstn = 1'b0;
    #10;
    check("reset_outputs", {vo, busy, error, drop, dout}, 64'h0);
    @(negedge clk) rstn = 1'b1;
    @(posedge clk); #1;

    // good packet: header 16, payload 01..05, parity 17
    clear_mon();
    for (int i = 0; i < 5; i++) pl[i] = 8'(i + 1);
    send_pkt(8'h16, 5, 8'h17);
    check("sf_hold_in_check", vo_s, 3'b000);
    @(posedge clk); #1;
    check("t1_valid_out", vo, 3'b100);
    check("sf_commit_valid", vo_s, 3'b100);
    check("t1_no_error", err_cnt, 0);
    exp_w[0] = 8'h16;
    for (int i = 0; i < 5; i++) exp_w[i+1] = 8'(i + 1);
    exp_w[6] = 8'h17;
    read_chk(2, 7, "t1_rd");
    check("t1_empty_after_read", vo, 3'b000);
    repeat (40) @(posedge clk);
    #1;
    check("sf_timeout_flush", vo_s, 3'b000);
    check("sf_no_error_good", err_s_cnt, 0);

    // bad parity: cut-through delivers, store-and-forward rolls back
    clear_mon();
    send_pkt(8'h16, 5, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    check("t2_error_pulses", err_cnt, 1);
    check("t2_sf_error_pulses", err_s_cnt, 1);
    check("t2_sf_never_valid", vo2_s_seen, 1'b0);
    check("t2_valid_out", vo, 3'b100);
    exp_w[6] = 8'h00;
    read_chk(2, 7, "t2_rd");
    check("t2_empty_after_read", vo, 3'b000);

    // invalid address is dropped
    repeat (3) @(posedge clk);
    #1;
    clear_mon();
    send_pkt(8'h17, 5, 8'hAB);
    repeat (3) @(posedge clk);
    #1;
    check("t3_drop_pulses", drop_cnt, 1);
    check("t3_no_valid", vo_seen, 3'b000);
    check("t3_never_busy", busy_cnt, 0);
    check("t3_no_error", err_cnt, 0);

    // oversize cut-through packet stalls on a full FIFO, then drains
    clear_mon();
    n_sent = 0; first_busy_at = -1;
    for (int i = 0; i < 20; i++) pl[i] = 8'(i + 1);
    exp_w[0] = 8'h50;
    for (int i = 0; i < 20; i++) exp_w[i+1] = 8'(i + 1);
    exp_w[21] = 8'h44;
    n = 0;
    fork
      send_pkt(8'h50, 20, 8'h44);
      begin
        int g;
        logic took;
        g = 0;
        @(negedge clk);
        while (!busy && g < 100) begin g++; @(negedge clk); end
        check("t4_busy_rises", busy, 1'b1);
        @(posedge clk); #1;
        g = 0;
        while (n < 22 && g < 300) begin
          took = vo[0];
          rd[0] = took;
          @(posedge clk); #1;
          if (took) begin
            check($sformatf("t4_rd[%0d]", n), dout[7:0], exp_w[n]);
            n++;
          end
          g++;
        end
        rd[0] = 1'b0;
      end
    join
    check("t4_words_read", n, 22);
    check("t4_full_after_16", first_busy_at, 16);
    check("t4_no_error", err_cnt, 0);
    check("t4_empty", vo, 3'b000);

    // unread channel is flushed by the timeout
    repeat (2) @(posedge clk);
    #1;
    clear_mon();
    pl[0] = 8'h3C;
    send_pkt(8'h05, 1, 8'h39);
    n = 0;
    @(negedge clk);
    while (vo[1] && n < 100) begin n++; @(negedge clk); end
    check("t5_valid_cycles", n, 31);
    check("t5_flushed", vo, 3'b000);
    check("t5_no_error", err_cnt, 0);
    check("t5_no_drop", drop_cnt, 0);

    // reset mid-payload, then a clean packet to port 0
    @(posedge clk); #1;
    send_byte(1'b1, 8'h10);
    send_byte(1'b1, 8'hA1);
    send_byte(1'b1, 8'hA2);
    #2 rstn = 1'b0;
    #1;
    check("t6_reset_outputs", {vo, busy, error, drop, dout}, 64'h0);
    pv = 1'b0; din = 8'h00;
    @(negedge clk) rstn = 1'b1;
    @(posedge clk); #1;
    clear_mon();
    pl[0] = 8'hAA; pl[1] = 8'h55;
    send_pkt(8'h08, 2, 8'hF7);
    @(posedge clk); #1;
    check("t6_valid_out", vo, 3'b001);
    exp_w[0] = 8'h08; exp_w[1] = 8'hAA; exp_w[2] = 8'h55; exp_w[3] = 8'hF7;
    read_chk(0, 4, "t6_rd");
    check("t6_no_error", err_cnt, 0);
    check("t6_empty", vo, 3'b000);
    check("no_stall_timeout", stall_tmo, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
